// File: rtl/example_sweep_ctrl.sv
// Self-test sequencer for the 2-input/1-output `example` block: sweeps {A,B}
// through 00,10,01,11, samples C at the end of each hold window and reports mismatches.
module example_sweep_ctrl #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] EXP_TT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a_out,
    output logic       b_out,
    input  logic       c_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] step, step_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] fail_mask_nxt;
    logic       pass_nxt;
    logic       a_nxt, b_nxt;
    logic [1:0] vec_idx;
    logic       mismatch;
    logic       hold_end;

    // The vector currently on the pins selects which expected bit C is checked against.
    assign vec_idx  = {a_out, b_out};
    assign mismatch = (c_in != EXP_TT[vec_idx]);
    assign hold_end = (hold_cnt == HOLD_LAST);

    assign busy = (state == RUN);
    assign done = (state == REPORT);

    always_comb begin
        state_nxt     = state;
        step_nxt      = step;
        hold_cnt_nxt  = hold_cnt;
        fail_mask_nxt = fail_mask;
        pass_nxt      = pass;
        a_nxt         = 1'b0;
        b_nxt         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = RUN;
                    step_nxt      = 2'd0;
                    hold_cnt_nxt  = 8'd0;
                    fail_mask_nxt = 4'b0000;
                    pass_nxt      = 1'b0;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt    = IDLE;
                    step_nxt     = 2'd0;
                    hold_cnt_nxt = 8'd0;
                    pass_nxt     = 1'b0;
                end else if (hold_end) begin
                    fail_mask_nxt = fail_mask | (4'(mismatch) << vec_idx);
                    hold_cnt_nxt  = 8'd0;
                    if (step == 2'd3) begin
                        state_nxt = REPORT;
                        step_nxt  = 2'd0;
                        pass_nxt  = (fail_mask_nxt == 4'b0000);
                    end else begin
                        step_nxt = step + 2'd1;
                        a_nxt    = step_nxt[0];
                        b_nxt    = step_nxt[1];
                    end
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                    a_nxt        = step[0];
                    b_nxt        = step[1];
                end
            end
            REPORT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            hold_cnt  <= 8'd0;
            fail_mask <= 4'b0000;
            pass      <= 1'b0;
            a_out     <= 1'b0;
            b_out     <= 1'b0;
        end else begin
            state     <= state_nxt;
            step      <= step_nxt;
            hold_cnt  <= hold_cnt_nxt;
            fail_mask <= fail_mask_nxt;
            pass      <= pass_nxt;
            a_out     <= a_nxt;
            b_out     <= b_nxt;
        end
    end

endmodule

// File: tb/tb_example_sweep_ctrl.sv
// Bench for example_sweep_ctrl: a default-parameter instance driving an AND/OR
// model of `example`, and a HOLD_CYCLES=1 instance driving an AND model.
module tb_example_sweep_ctrl;

    localparam logic [3:0] EXP_TT = 4'b1000;
    localparam int         H0     = 10;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [3:0] mask;
    } exp_t;

    typedef struct {
        string      name;
        bit         orm;
        int         abort_at;
        int         re0;
        int         re1;
        int         n_done;
        bit         fin_pass;
        logic [3:0] fin_mask;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       or_mode = 1'b0;
    logic       a0, b0, c0, busy0, done0, pass0;
    logic [3:0] mask0;
    logic       start1 = 1'b0;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [3:0] mask1;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign c0 = or_mode ? (a0 | b0) : (a0 & b0);
    assign c1 = a1 & b1;

    example_sweep_ctrl #(.HOLD_CYCLES(H0), .EXP_TT(EXP_TT)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .a_out(a0), .b_out(b0), .c_in(c0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_mask(mask0)
    );

    example_sweep_ctrl #(.HOLD_CYCLES(1), .EXP_TT(EXP_TT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(1'b0),
        .a_out(a1), .b_out(b1), .c_in(c1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_mask(mask1)
    );

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {a,b,busy,done,pass,mask}=%09b expected %09b", name, act, exp);
        end
    endtask

    // Expected outputs k cycles after the start edge of one sweep.
    function automatic exp_t model(input int k, input int h, input bit orm, input int abort_at);
        exp_t       e;
        int         km;
        logic [1:0] sv;
        logic       c;
        logic [1:0] cur;
        e  = '0;
        km = (abort_at >= 0 && k > abort_at) ? abort_at : k;
        for (int s = 0; s < 4; s++) begin
            if ((s + 1) * h <= km) begin
                sv = s[1:0];
                c  = orm ? (sv[0] | sv[1]) : (sv[0] & sv[1]);
                if (c != EXP_TT[{sv[0], sv[1]}]) e.mask[{sv[0], sv[1]}] = 1'b1;
            end
        end
        if (abort_at >= 0 && k > abort_at) begin
            e.busy = 1'b0;
        end else if (k < 4 * h) begin
            cur    = 2'(k / h);
            e.busy = 1'b1;
            e.a    = cur[0];
            e.b    = cur[1];
        end else begin
            e.done = (k == 4 * h);
            e.pass = (e.mask == 4'b0000);
        end
        return e;
    endfunction

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   n_done;
        n_done = 0;
        @(negedge clk);
        or_mode = v.orm;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4 * H0 + 4; k++) begin
            sb_q.push_back(model(k, H0, v.orm, v.abort_at));
            e = sb_q.pop_front();
            chk($sformatf("%s k=%0d", v.name, k),
                {a0, b0, busy0, done0, pass0, mask0}, e);
            if (done0) n_done++;
            abort = (k == v.abort_at);
            start = (k == v.re0) || (k == v.re1);
            @(negedge clk);
        end
        abort = 1'b0;
        start = 1'b0;
        chk({v.name, " final"}, {5'b0, pass0, mask0}, {5'b0, v.fin_pass, v.fin_mask});
        chk({v.name, " done_count"}, 9'(n_done), 9'(v.n_done));
    endtask

    vec_t vecs[4];

    initial begin
        exp_t e;
        int   n_done;

        vecs[0] = '{"and_ok",      1'b0, -1, -1, -1, 1, 1'b1, 4'b0000};
        vecs[1] = '{"or_model",    1'b1, -1, -1, -1, 1, 1'b0, 4'b0110};
        vecs[2] = '{"abort15",     1'b0, 15, -1, -1, 0, 1'b0, 4'b0000};
        vecs[3] = '{"restart_ign", 1'b0, -1,  5, 20, 1, 1'b1, 4'b0000};

        #2;
        chk("reset dut0", {a0, b0, busy0, done0, pass0, mask0}, 9'b0);
        chk("reset dut1", {a1, b1, busy1, done1, pass1, mask1}, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // HOLD_CYCLES=1 with start held: sweeps repeat with one idle cycle between.
        n_done = 0;
        start1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            sb_q.push_back(model(k % 6, 1, 1'b0, -1));
            e = sb_q.pop_front();
            chk($sformatf("hold1 k=%0d", k), {a1, b1, busy1, done1, pass1, mask1}, e);
            if (done1) n_done++;
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("hold1 done_count", 9'(n_done), 9'd2);
        repeat (8) @(negedge clk);

        // Mid-sweep reset: outputs clear without waiting for a clock edge.
        or_mode = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("pre_reset k=25", {a0, b0, busy0, done0, pass0, mask0}, model(25, H0, 1'b0, -1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", {a0, b0, busy0, done0, pass0, mask0}, 9'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 4 * H0 + 4; k++) begin
            if (done0 || busy0) n_done++;
            @(negedge clk);
        end
        chk("post_reset quiet", 9'(n_done), 9'd0);
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
